timebase_gen: RTL and testbench

//  Turns the 10 MHz system PLL output into the design's time references.

---
 rtl/clock_pkg.sv | 36 +++
 rtl/mod_counter.sv | 49 ++++
 rtl/timebase_gen.sv | 140 ++++++++++++++
 tb/tb_timebase_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared timing constants for every block that counts time.
//
// Contents:
//   SYS_CLK_HZ  nominal frequency of the PLL output clock
//   TICK_HZ     nominal rate of the fast (millisecond) strobe
//   SLOW_DIV    nominal fast ticks per second
//   clog2()     elaboration-time ceiling log2, usable in port widths
//   MS_CNT_W    width of a millisecond-within-second index, so that any
//               downstream counter keyed off ms_cnt uses the same width
//   ms_cnt_t    packed type of that index
package clock_pkg;

    localparam int SYS_CLK_HZ = 10_000_000;
    localparam int TICK_HZ    = 1000;
    localparam int SLOW_DIV   = 1000;

    // Number of bits needed to hold the values 0 .. value-1.
    // A value of 1 or less yields 0, so callers that need a real
    // vector must guarantee value >= 2.
    function automatic int clog2(input int value);
        int bits;
        int rem;
        bits = 0;
        rem  = value - 1;
        while (rem > 0) begin
            bits = bits + 1;
            rem  = rem >> 1;
        end
        return bits;
    endfunction

    localparam int MS_CNT_W = clog2(SLOW_DIV);

    typedef logic [MS_CNT_W-1:0] ms_cnt_t;

endpackage

// File: rtl/mod_counter.sv
// Generic modulo-MOD wrap counter.
//
// Ports:
//   clk   in   1  clock
//   rst   in   1  synchronous reset, active high, forces q to 0
//   clr   in   1  synchronous clear, forces q to 0 (lower priority than rst)
//   en    in   1  advance by one, wrapping MOD-1 -> 0
//   q     out  W  current count, 0 .. MOD-1
//   wrap  out  1  combinational: high when en is asserted while q == MOD-1,
//                 i.e. this edge takes the counter back to 0
module mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    // The counter must be able to represent MOD-1.
    if (MOD < 2 || (MOD - 1) >= (2 ** W)) begin : g_bad_mod
        $error("mod_counter: MOD must be >= 2 and MOD-1 must fit in W bits");
    end

    // wrap is left combinational so the owner can register it alongside
    // its own outputs and keep every strobe aligned to the same edge.
    assign wrap = en && (q == LAST);

    // Reset dominates clear, clear dominates counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (q == LAST) begin
                q <= '0;
            end else begin
                q <= q + W'(1);
            end
        end
    end

endmodule

// File: rtl/timebase_gen.sv
// Time-reference generator sitting directly behind the system PLL.
//
// A cycle prescaler divides clk down to a one-cycle fast strobe at TICK_HZ.
// A modulo-SLOW_DIV counter of fast strobes gives the millisecond index and
// a one-cycle strobe once per second. The last millisecond of every second
// is stretched or shortened by a signed trim to correct crystal error; the
// trim is only picked up at a second boundary or on sync so a second is
// never split between two trim values.
//
// Ports:
//   clk        in   1               PLL output clock, the only clock
//   rst        in   1               synchronous reset, active high
//   sync       in   1               synchronous realign: restarts the
//                                   second and reloads the trim
//   trim_val   in   TRIM_W          signed cycle offset for the last ms
//   tick_fast  out  1               one-cycle strobe at TICK_HZ
//   tick_slow  out  1               one-cycle strobe once per SLOW_DIV
//                                   fast ticks, coincident with tick_fast
//   half_sec   out  1               high while ms_cnt < SLOW_DIV/2
//   ms_cnt     out  clog2(SLOW_DIV) fast-tick index within the second
module timebase_gen #(
    parameter int CLK_HZ   = clock_pkg::SYS_CLK_HZ,
    parameter int TICK_HZ  = clock_pkg::TICK_HZ,
    parameter int SLOW_DIV = clock_pkg::SLOW_DIV,
    parameter int TRIM_W   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sync,
    input  logic [TRIM_W-1:0]                    trim_val,
    output logic                                 tick_fast,
    output logic                                 tick_slow,
    output logic                                 half_sec,
    output logic [clock_pkg::clog2(SLOW_DIV)-1:0] ms_cnt
);

    localparam int FAST_DIV = CLK_HZ / TICK_HZ;
    localparam int MS_W     = clock_pkg::clog2(SLOW_DIV);

    // Wide enough for the longest stretched millisecond,
    // FAST_DIV + 2**(TRIM_W-1) - 1. Because FAST_DIV > 2**(TRIM_W-1),
    // this is always strictly wider than the trim itself.
    localparam int DIV_W = clock_pkg::clog2(FAST_DIV + 2 ** (TRIM_W - 1));

    localparam logic [DIV_W-1:0] BASE_LAST = DIV_W'(FAST_DIV - 1);
    localparam logic [MS_W-1:0]  MS_LAST   = MS_W'(SLOW_DIV - 1);
    localparam logic [MS_W-1:0]  MS_HALF   = MS_W'(SLOW_DIV / 2);

    // Parameter sanity: reject configurations that cannot be built.
    if (TICK_HZ <= 0 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_ratio
        $error("timebase_gen: CLK_HZ must be an exact multiple of TICK_HZ");
    end
    if (SLOW_DIV < 2 || (SLOW_DIV % 2) != 0) begin : g_bad_slow_div
        $error("timebase_gen: SLOW_DIV must be even and at least 2");
    end
    if (TRIM_W < 1 || FAST_DIV <= 2 ** (TRIM_W - 1)) begin : g_bad_trim
        $error("timebase_gen: FAST_DIV must exceed 2**(TRIM_W-1)");
    end

    logic [DIV_W-1:0]  div_cnt;
    logic [TRIM_W-1:0] trim_q;
    logic [DIV_W-1:0]  trim_ext;
    logic [DIV_W-1:0]  last_cnt;
    logic              terminal;
    logic              ms_wrap;
    logic [MS_W-1:0]   ms_next;

    // Terminal-count selection. Only the last millisecond of a second
    // carries the trim; adding the sign-extended trim modulo 2**DIV_W gives
    // the correct shortened or stretched end count because the result is
    // always positive and fits in DIV_W bits.
    always_comb begin
        trim_ext = {{(DIV_W - TRIM_W){trim_q[TRIM_W-1]}}, trim_q};
        last_cnt = BASE_LAST;
        if (ms_cnt == MS_LAST) begin
            last_cnt = BASE_LAST + trim_ext;
        end
        terminal = (div_cnt == last_cnt);
    end

    // Millisecond index within the second. Counts terminal events and is
    // cleared by sync, so a realign restarts the second at ms 0.
    mod_counter #(
        .MOD (SLOW_DIV),
        .W   (MS_W)
    ) u_ms_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (sync),
        .en   (terminal),
        .q    (ms_cnt),
        .wrap (ms_wrap)
    );

    // Value ms_cnt will take at the next edge when neither rst nor sync is
    // active; half_sec is registered from it so both move on the same edge.
    always_comb begin
        ms_next = ms_cnt;
        if (terminal) begin
            if (ms_wrap) begin
                ms_next = '0;
            end else begin
                ms_next = ms_cnt + MS_W'(1);
            end
        end
    end

    // Prescaler, registered strobes, half-second level and trim capture.
    // rst wins over sync, and sync wins over a terminal count in the same
    // cycle, which is what suppresses the strobe on a realign. A new trim
    // is latched only on the second wrap or on sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            tick_fast <= 1'b0;
            tick_slow <= 1'b0;
            half_sec  <= 1'b1;
            trim_q    <= '0;
        end else if (sync) begin
            div_cnt   <= '0;
            tick_fast <= 1'b0;
            tick_slow <= 1'b0;
            half_sec  <= 1'b1;
            trim_q    <= trim_val;
        end else begin
            if (terminal) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            tick_fast <= terminal;
            tick_slow <= ms_wrap;
            half_sec  <= (ms_next < MS_HALF);
            if (ms_wrap) begin
                trim_q <= trim_val;
            end
        end
    end

endmodule

// File: tb/tb_timebase_gen.sv
// Self-checking bench for timebase_gen with a small configuration:
// CLK_HZ=100, TICK_HZ=10 (FAST_DIV=10), SLOW_DIV=4, TRIM_W=4.
//
// The reference model tracks position within the current second as a plain
// cycle offset and derives every output from that offset with arithmetic:
// a second is SLOW_DIV*FAST_DIV + trim cycles long, ms boundaries fall on
// multiples of FAST_DIV, and the final ms absorbs the trim.
module tb_timebase_gen;

    localparam int CLK_HZ   = 100;
    localparam int TICK_HZ  = 10;
    localparam int SLOW_DIV = 4;
    localparam int TRIM_W   = 4;
    localparam int FD       = CLK_HZ / TICK_HZ;
    localparam int MSW      = 2;

    localparam logic [TRIM_W-1:0] TRIM_ZERO = 4'd0;
    localparam logic [TRIM_W-1:0] TRIM_P3   = 4'd3;
    localparam logic [TRIM_W-1:0] TRIM_M5   = 4'b1011;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync = 1'b0;
    logic [TRIM_W-1:0] trim_val = '0;
    logic              tick_fast;
    logic              tick_slow;
    logic              half_sec;
    logic [MSW-1:0]    ms_cnt;

    int total = 0;
    int bad   = 0;

    // Model state: offset within current second, whether that second began
    // with a natural wrap (rather than rst/sync), the trim in force, and the
    // cycle number since the last rst/sync.
    int p      = 0;
    int nat    = 0;
    int trim_m = 0;
    int cyc    = 0;

    timebase_gen #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .SLOW_DIV (SLOW_DIV),
        .TRIM_W   (TRIM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sync      (sync),
        .trim_val  (trim_val),
        .tick_fast (tick_fast),
        .tick_slow (tick_slow),
        .half_sec  (half_sec),
        .ms_cnt    (ms_cnt)
    );

    always #5 clk = ~clk;

    // Expected {tick_fast, tick_slow, half_sec, ms_cnt} for the current offset.
    function automatic logic [4:0] expect_out();
        int  ms;
        logic tf;
        logic ts;
        logic hs;
        ms = p / FD;
        if (ms > SLOW_DIV - 1) ms = SLOW_DIV - 1;
        ts = (p == 0) && (nat != 0);
        tf = ts || ((p > 0) && (p % FD == 0) && (p <= (SLOW_DIV - 1) * FD));
        hs = (ms < SLOW_DIV / 2);
        return {tf, ts, hs, MSW'(ms)};
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, then
    // park on the falling edge where outputs are stable.
    task automatic step(input logic r, input logic s, input logic [TRIM_W-1:0] tv);
        rst      = r;
        sync     = s;
        trim_val = tv;
        @(posedge clk);
        if (r) begin
            p = 0; nat = 0; trim_m = 0; cyc = 0;
        end else if (s) begin
            p = 0; nat = 0; trim_m = int'($signed(tv)); cyc = 0;
        end else begin
            cyc = cyc + 1;
            if (p + 1 == SLOW_DIV * FD + trim_m) begin
                p = 0; nat = 1; trim_m = int'($signed(tv));
            end else begin
                p = p + 1; nat = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, TRIM_P3);
        total++;
        if (tick_fast !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_tick_fast got=%b exp=0", tick_fast);
        end
        total++;
        if (tick_slow !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_tick_slow got=%b exp=0", tick_slow);
        end
        total++;
        if (half_sec !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_half_sec got=%b exp=1", half_sec);
        end
        total++;
        if (ms_cnt !== 2'd0) begin
            bad++; $display("[TB] FAIL reset_ms_cnt got=%0d exp=0", ms_cnt);
        end
    endtask

    task automatic test_basic();
        int first_fast;
        int first_slow;
        logic [4:0] got;
        logic [4:0] exp;
        first_fast = -1;
        first_slow = -1;
        step(1'b1, 1'b0, TRIM_ZERO);
        for (int i = 0; i < 45; i++) begin
            step(1'b0, 1'b0, TRIM_ZERO);
            got = {tick_fast, tick_slow, half_sec, ms_cnt};
            exp = expect_out();
            total++;
            if (got !== exp) begin
                bad++; $display("[TB] FAIL basic cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            if (tick_fast === 1'b1 && first_fast < 0) first_fast = cyc;
            if (tick_slow === 1'b1 && first_slow < 0) first_slow = cyc;
        end
        total++;
        if (first_fast != FD) begin
            bad++; $display("[TB] FAIL basic_first_fast got=%0d exp=%0d", first_fast, FD);
        end
        total++;
        if (first_slow != 40) begin
            bad++; $display("[TB] FAIL basic_first_slow got=%0d exp=40", first_slow);
        end
    endtask

    task automatic test_trim();
        int slow_q[$];
        int exp_slow[3];
        logic [TRIM_W-1:0] tv;
        logic [4:0] got;
        logic [4:0] exp;
        exp_slow = '{40, 83, 118};
        step(1'b1, 1'b0, TRIM_ZERO);
        for (int i = 0; i < 125; i++) begin
            tv = (cyc < 30) ? TRIM_ZERO : ((cyc < 55) ? TRIM_P3 : TRIM_M5);
            step(1'b0, 1'b0, tv);
            got = {tick_fast, tick_slow, half_sec, ms_cnt};
            exp = expect_out();
            total++;
            if (got !== exp) begin
                bad++; $display("[TB] FAIL trim cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            if (tick_slow === 1'b1) slow_q.push_back(cyc);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= slow_q.size() || slow_q[i] != exp_slow[i]) begin
                bad++;
                $display("[TB] FAIL trim_slow_%0d got=%0d exp=%0d", i,
                         (i < slow_q.size()) ? slow_q[i] : -1, exp_slow[i]);
            end
        end
    endtask

    task automatic test_sync_mid();
        int n;
        logic [4:0] got;
        logic [4:0] exp;
        step(1'b1, 1'b0, TRIM_ZERO);
        for (int i = 0; i < 25; i++) step(1'b0, 1'b0, TRIM_ZERO);
        step(1'b0, 1'b1, TRIM_ZERO);
        total++;
        if ({ms_cnt, half_sec, tick_fast} !== {2'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("[TB] FAIL sync_mid_restart got ms=%0d hs=%b tf=%b exp ms=0 hs=1 tf=0",
                     ms_cnt, half_sec, tick_fast);
        end
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            step(1'b0, 1'b0, TRIM_ZERO);
            got = {tick_fast, tick_slow, half_sec, ms_cnt};
            exp = expect_out();
            total++;
            if (got !== exp) begin
                bad++; $display("[TB] FAIL sync_mid cyc=%0d got=%b exp=%b", cyc, got, exp);
            end
            if (tick_fast === 1'b1) n = i;
        end
        total++;
        if (n != FD) begin
            bad++; $display("[TB] FAIL sync_mid_next_tick got=%0d exp=%0d", n, FD);
        end
    endtask

    task automatic test_sync_terminal();
        int n;
        step(1'b1, 1'b0, TRIM_ZERO);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, TRIM_ZERO);
        step(1'b0, 1'b1, TRIM_ZERO);
        total++;
        if (tick_fast !== 1'b0) begin
            bad++; $display("[TB] FAIL sync_term_suppress got=%b exp=0", tick_fast);
        end
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            step(1'b0, 1'b0, TRIM_ZERO);
            if (tick_fast === 1'b1) n = i;
        end
        total++;
        if (n != FD) begin
            bad++; $display("[TB] FAIL sync_term_next_tick got=%0d exp=%0d", n, FD);
        end
    endtask

    task automatic test_rst_mid();
        int nf;
        int ns;
        step(1'b1, 1'b0, TRIM_ZERO);
        step(1'b0, 1'b1, TRIM_P3);
        for (int i = 0; i < 33; i++) step(1'b0, 1'b0, TRIM_P3);
        step(1'b1, 1'b0, TRIM_P3);
        total++;
        if ({tick_fast, tick_slow, half_sec, ms_cnt} !== 5'b00100) begin
            bad++;
            $display("[TB] FAIL rst_mid_outputs got=%b exp=00100",
                     {tick_fast, tick_slow, half_sec, ms_cnt});
        end
        nf = 0;
        ns = 0;
        for (int i = 1; i <= 80 && ns == 0; i++) begin
            step(1'b0, 1'b0, TRIM_P3);
            if (tick_fast === 1'b1 && nf == 0) nf = i;
            if (tick_slow === 1'b1) ns = i;
        end
        total++;
        if (nf != FD) begin
            bad++; $display("[TB] FAIL rst_mid_next_tick got=%0d exp=%0d", nf, FD);
        end
        total++;
        if (ns != SLOW_DIV * FD) begin
            bad++; $display("[TB] FAIL rst_mid_trim_cleared got=%0d exp=%0d", ns, SLOW_DIV * FD);
        end
    endtask

    task automatic test_random();
        logic r;
        logic s;
        logic [TRIM_W-1:0] tv;
        logic [4:0] got;
        logic [4:0] exp;
        tv = TRIM_ZERO;
        step(1'b1, 1'b0, TRIM_ZERO);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) tv = TRIM_W'($urandom_range(0, 15));
            step(r, s, tv);
            got = {tick_fast, tick_slow, half_sec, ms_cnt};
            exp = expect_out();
            total++;
            if (got !== exp) begin
                bad++;
                $display("[TB] FAIL random i=%0d p=%0d trim=%0d got=%b exp=%b",
                         i, p, trim_m, got, exp);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_trim();
        test_sync_mid();
        test_sync_terminal();
        test_rst_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
